// File: rtl/bar_arb_pkg.sv
// rtl/bar_arb_pkg.sv - shared types and helpers for the handshake round-robin arbiter
package bar_arb_pkg;

  // Number of requesters handled by this revision of the arbiter.
  localparam int N_REQ = 3;

  // Requester index (0..2).
  typedef logic [1:0] id_t;

  // IDLE: free to arbitrate; BURST: a packet from the locked requester is open.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Add a small offset (0..2) to a requester index, wrapping modulo 3.
  function automatic id_t id_add(input id_t base, input id_t offs);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, offs};
    if (sum >= 3'd3) begin
      sum = sum - 3'd3;
    end
    return sum[1:0];
  endfunction

  // One-hot request mask for a requester index.
  function automatic logic [2:0] id_to_onehot(input id_t id);
    logic [2:0] mask;
    mask = 3'b000;
    case (id)
      2'd0:    mask = 3'b001;
      2'd1:    mask = 3'b010;
      2'd2:    mask = 3'b100;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/handshake_rr_arbiter_rr_pick.sv
// rtl/handshake_rr_arbiter_rr_pick.sv - combinational round-robin pick starting at ptr
module rr_pick
  import bar_arb_pkg::*;
(
  input  logic [2:0] req_i,
  input  id_t        ptr_i,
  output logic [2:0] grant_o,
  output id_t        grant_id_o
);

  // Scan ptr+2, ptr+1, ptr so the nearest valid requester from ptr wins last.
  always_comb begin
    id_t cand;
    grant_o    = 3'b000;
    grant_id_o = '0;
    for (int k = 2; k >= 0; k--) begin
      cand = id_add(ptr_i, id_t'(k));
      if (req_i[cand]) begin
        grant_o    = id_to_onehot(cand);
        grant_id_o = cand;
      end
    end
  end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// rtl/handshake_rr_arbiter.sv - 3-way packet-locked round-robin arbiter with registered output
module handshake_rr_arbiter
  import bar_arb_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N_REQ = bar_arb_pkg::N_REQ
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             handshake_arr_0_valid,
  output logic             handshake_arr_0_ready,
  input  logic [WIDTH-1:0] handshake_arr_0_data,
  input  logic             handshake_arr_0_last,
  input  logic             handshake_arr_1_valid,
  output logic             handshake_arr_1_ready,
  input  logic [WIDTH-1:0] handshake_arr_1_data,
  input  logic             handshake_arr_1_last,
  input  logic             handshake_arr_2_valid,
  output logic             handshake_arr_2_ready,
  input  logic [WIDTH-1:0] handshake_arr_2_data,
  input  logic             handshake_arr_2_last,
  output logic             handshake_valid,
  input  logic             handshake_ready,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       out_id,
  output logic             out_last
);

  arb_state_t       state_q;
  id_t              ptr_q;
  id_t              lock_q;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  id_t              out_id_q, out_id_d;
  logic             out_last_q, out_last_d;

  logic [N_REQ-1:0] req_vec;
  logic [2:0]       pick_grant;
  id_t              pick_id;
  logic [2:0]       grant;
  id_t              grant_id;
  logic [2:0]       ready_vec;
  logic             load;
  logic             accept;
  logic [WIDTH-1:0] acc_data;
  logic             acc_last;

  assign req_vec = {handshake_arr_2_valid, handshake_arr_1_valid, handshake_arr_0_valid};

  // The output register can take a new word when empty or being drained this cycle.
  assign load = !valid_q || handshake_ready;

  rr_pick u_pick (
    .req_i      (req_vec),
    .ptr_i      (ptr_q),
    .grant_o    (pick_grant),
    .grant_id_o (pick_id)
  );

  // Grant source: round-robin pick when idle, the locked requester only while a packet is open.
  always_comb begin
    grant    = 3'b000;
    grant_id = pick_id;
    if (state_q == BURST) begin
      grant_id = lock_q;
      grant    = req_vec & id_to_onehot(lock_q);
    end else begin
      grant = pick_grant;
    end
  end

  // Readies depend only on valids, state, ptr, lock and downstream ready; never on payload.
  always_comb begin
    ready_vec = 3'b000;
    if (!RESET && load) begin
      ready_vec = grant;
    end
  end

  assign accept = |ready_vec;

  assign handshake_arr_0_ready = ready_vec[0];
  assign handshake_arr_1_ready = ready_vec[1];
  assign handshake_arr_2_ready = ready_vec[2];

  // Steer the granted requester's payload and last flag toward the output register.
  always_comb begin
    acc_data = handshake_arr_0_data;
    acc_last = handshake_arr_0_last;
    case (grant_id)
      2'd1: begin
        acc_data = handshake_arr_1_data;
        acc_last = handshake_arr_1_last;
      end
      2'd2: begin
        acc_data = handshake_arr_2_data;
        acc_last = handshake_arr_2_last;
      end
      default: begin
        acc_data = handshake_arr_0_data;
        acc_last = handshake_arr_0_last;
      end
    endcase
  end

  // Output register next state: load on accept, empty on unrefilled drain, else hold.
  always_comb begin
    valid_d    = valid_q;
    out_d      = out_q;
    out_id_d   = out_id_q;
    out_last_d = out_last_q;
    if (accept) begin
      valid_d    = 1'b1;
      out_d      = acc_data;
      out_id_d   = grant_id;
      out_last_d = acc_last;
    end else if (load) begin
      valid_d = 1'b0;
    end
  end

  // Output register update; reset drops any buffered word.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q    <= 1'b0;
      out_q      <= '0;
      out_id_q   <= '0;
      out_last_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      out_q      <= out_d;
      out_id_q   <= out_id_d;
      out_last_q <= out_last_d;
    end
  end

  // Packet-lock FSM with round-robin pointer; advances only on accepted words.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      lock_q  <= '0;
    end else if (accept) begin
      if (acc_last) begin
        state_q <= IDLE;
        ptr_q   <= id_add(grant_id, 2'd1);
      end else begin
        state_q <= BURST;
        lock_q  <= grant_id;
      end
    end
  end

  assign handshake_valid = valid_q;
  assign out             = out_q;
  assign out_id          = out_id_q;
  assign out_last        = out_last_q;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// tb/tb_handshake_rr_arbiter.sv - self-checking bench for handshake_rr_arbiter
module tb_handshake_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [2:0] vld;
  logic [2:0] lst;
  logic [3:0] dat [3];
  logic       hready;
  logic       r0, r1, r2;
  logic       hvalid;
  logic [3:0] dout;
  logic [1:0] did;
  logic       dlast;

  int checks = 0;
  int errors = 0;

  handshake_rr_arbiter #(.WIDTH(4), .N_REQ(3)) dut (
    .CLK                   (clk),
    .RESET                 (rst),
    .handshake_arr_0_valid (vld[0]),
    .handshake_arr_0_ready (r0),
    .handshake_arr_0_data  (dat[0]),
    .handshake_arr_0_last  (lst[0]),
    .handshake_arr_1_valid (vld[1]),
    .handshake_arr_1_ready (r1),
    .handshake_arr_1_data  (dat[1]),
    .handshake_arr_1_last  (lst[1]),
    .handshake_arr_2_valid (vld[2]),
    .handshake_arr_2_ready (r2),
    .handshake_arr_2_data  (dat[2]),
    .handshake_arr_2_last  (lst[2]),
    .handshake_valid       (hvalid),
    .handshake_ready       (hready),
    .out                   (dout),
    .out_id                (did),
    .out_last              (dlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: packet lock, round-robin pointer and a one-entry output slot.
  logic       m_valid = 1'b0;
  logic [3:0] m_out   = 4'd0;
  int         m_id    = 0;
  logic       m_last  = 1'b0;
  bit         m_burst = 1'b0;
  int         m_lock  = 0;
  int         m_ptr   = 0;

  always @(negedge clk) begin
    logic [2:0] exp_r;
    bit         can_take;
    int         src;
    exp_r    = 3'b000;
    can_take = !m_valid || hready;
    src      = -1;
    if (!rst && can_take) begin
      if (m_burst) begin
        if (vld[m_lock]) src = m_lock;
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (src < 0 && vld[(m_ptr + k) % 3]) src = (m_ptr + k) % 3;
        end
      end
    end
    if (src >= 0) exp_r[src] = 1'b1;

    check("readies", {29'd0, r2, r1, r0}, {29'd0, exp_r});
    check("ready_onehot0", {31'd0, $onehot0({r2, r1, r0})}, 32'd1);
    check("out_valid", {31'd0, hvalid}, {31'd0, m_valid});
    if (m_valid) begin
      check("out_data", {28'd0, dout}, {28'd0, m_out});
      check("out_id", {30'd0, did}, m_id);
      check("out_last", {31'd0, dlast}, {31'd0, m_last});
    end

    if (rst) begin
      m_valid = 1'b0; m_out = 4'd0; m_id = 0; m_last = 1'b0;
      m_burst = 1'b0; m_lock = 0; m_ptr = 0;
    end else if (src >= 0) begin
      m_valid = 1'b1;
      m_out   = dat[src];
      m_id    = src;
      m_last  = lst[src];
      if (lst[src]) begin
        m_burst = 1'b0;
        m_ptr   = (src + 1) % 3;
      end else begin
        m_burst = 1'b1;
        m_lock  = src;
      end
    end else if (can_take) begin
      m_valid = 1'b0;
    end
  end

  task automatic drive(input logic [2:0] v, input logic [2:0] l, input logic hr, input logic r);
    @(posedge clk);
    #1;
    rst    = r;
    vld    = v;
    lst    = l;
    hready = hr;
    for (int i = 0; i < 3; i++) dat[i] = 4'($urandom_range(0, 15));
  endtask

  task automatic pin_r(input string name, input logic [2:0] exp);
    @(negedge clk);
    check(name, {29'd0, r2, r1, r0}, {29'd0, exp});
  endtask

  initial begin
    rst = 1'b1; vld = 3'b000; lst = 3'b000; hready = 1'b1;
    for (int i = 0; i < 3; i++) dat[i] = 4'd0;

    // Reset: readies low even with every requester valid, output cleared.
    drive(3'b111, 3'b111, 1'b1, 1'b1);
    drive(3'b111, 3'b111, 1'b1, 1'b1);
    pin_r("rst_readies", 3'b000);
    drive(3'b000, 3'b000, 1'b1, 1'b0);
    @(negedge clk);
    check("rst_valid", {31'd0, hvalid}, 32'd0);
    check("rst_out", {28'd0, dout}, 32'd0);
    check("rst_id", {30'd0, did}, 32'd0);
    check("rst_last", {31'd0, dlast}, 32'd0);

    // All valid, single-word packets: grants rotate 0,1,2,0.
    drive(3'b111, 3'b111, 1'b1, 1'b0); pin_r("rr_g0", 3'b001);
    drive(3'b111, 3'b111, 1'b1, 1'b0); pin_r("rr_g1", 3'b010);
    check("rr_id0", {30'd0, did}, 32'd0);
    drive(3'b111, 3'b111, 1'b1, 1'b0); pin_r("rr_g2", 3'b100);
    check("rr_id1", {30'd0, did}, 32'd1);
    drive(3'b111, 3'b111, 1'b1, 1'b0); pin_r("rr_g3", 3'b001);
    check("rr_id2", {30'd0, did}, 32'd2);
    drive(3'b000, 3'b000, 1'b1, 1'b0); pin_r("rr_none", 3'b000);

    // Req1 three-word packet with a gap; others locked out, then req2 next.
    drive(3'b111, 3'b000, 1'b1, 1'b0); pin_r("pkt_w1", 3'b010);
    drive(3'b111, 3'b000, 1'b1, 1'b0); pin_r("pkt_w2", 3'b010);
    check("pkt_id_w1", {30'd0, did}, 32'd1);
    drive(3'b101, 3'b000, 1'b1, 1'b0); pin_r("pkt_gap", 3'b000);
    drive(3'b111, 3'b010, 1'b1, 1'b0); pin_r("pkt_w3", 3'b010);
    drive(3'b111, 3'b111, 1'b1, 1'b0); pin_r("pkt_after", 3'b100);
    check("pkt_last", {31'd0, dlast}, 32'd1);

    // Backpressure for four cycles, then readies resume with downstream ready.
    drive(3'b111, 3'b111, 1'b1, 1'b0); pin_r("bp_g0", 3'b001);
    for (int i = 0; i < 4; i++) begin
      drive(3'b111, 3'b111, 1'b0, 1'b0); pin_r("bp_hold", 3'b000);
      check("bp_id", {30'd0, did}, 32'd0);
    end
    drive(3'b111, 3'b111, 1'b1, 1'b0); pin_r("bp_resume", 3'b010);

    // Req2 alone wraps the pointer; req0 wins over req2 next.
    drive(3'b100, 3'b100, 1'b1, 1'b0); pin_r("wrap_g2", 3'b100);
    drive(3'b101, 3'b111, 1'b1, 1'b0); pin_r("wrap_g0", 3'b001);

    // Reset mid-burst from req1 drops lock and buffered word.
    drive(3'b010, 3'b000, 1'b1, 1'b0); pin_r("rb_w1", 3'b010);
    drive(3'b010, 3'b000, 1'b1, 1'b0); pin_r("rb_w2", 3'b010);
    drive(3'b010, 3'b000, 1'b1, 1'b1); pin_r("rb_rst", 3'b000);
    drive(3'b000, 3'b000, 1'b1, 1'b0);
    @(negedge clk);
    check("rb_valid", {31'd0, hvalid}, 32'd0);
    drive(3'b111, 3'b111, 1'b1, 1'b0); pin_r("rb_g0", 3'b001);

    // Random traffic with occasional resets; the model checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) == 0));
    end
    drive(3'b000, 3'b000, 1'b1, 1'b0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/handshake_rr_arbiter.md
HANDSHAKE_RR_ARBITER -- requirements
Module: handshake_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, payload bit width per requester and output.
REQ-002 Parameter N_REQ, default 3, number of requesters; fixed at 3 in this revision.
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 handshake_arr_<i>_valid  input  1  requester i (i=0..2) offers a word.
REQ-006 handshake_arr_<i>_ready  output  1  arbiter accepts requester i's word this cycle.
REQ-007 handshake_arr_<i>_data  input  WIDTH  requester i payload.
REQ-008 handshake_arr_<i>_last  input  1  word is the final word of requester i's packet.
REQ-009 handshake_valid  output  1  output register holds a word.
REQ-010 handshake_ready  input  1  downstream consumes the output word.
REQ-011 out  output  WIDTH  output payload.
REQ-012 out_id  output  2  source requester index of `out`.
REQ-013 out_last  output  1  `last` flag of `out`.

Function
REQ-014 Transfer on any port SHALL occur only in a cycle where valid && ready are both high.
REQ-015 Definition: load = !handshake_valid || handshake_ready.
REQ-016 handshake_arr_<i>_ready SHALL be high only when load is high and i is the granted requester; at most one ready is high per cycle.
REQ-017 FSM states SHALL be IDLE (no packet in progress) and BURST (packet from lock_id in progress).
REQ-018 In IDLE, grant SHALL go to the first valid requester searching ptr, ptr+1, ptr+2 (mod 3).
REQ-019 In BURST, grant SHALL go to lock_id only; other requesters SHALL see ready low regardless of their valid.
REQ-020 On an accepted word with last=0, the FSM SHALL enter or stay in BURST with lock_id = source.
REQ-021 On an accepted word with last=1, the FSM SHALL return to IDLE and set ptr = (source+1) mod 3 (2 wraps to 0).
REQ-022 An accepted word SHALL appear on out/out_id/out_last with handshake_valid high on the next cycle; latency 1 cycle.
REQ-023 If load is high with no accepted word, handshake_valid SHALL go low next cycle.
REQ-024 If the output drains and a new word is accepted in the same cycle, the output register SHALL load the new word; sustained throughput SHALL be 1 word per cycle.
REQ-025 While handshake_valid && !handshake_ready, out, out_id and out_last SHALL hold stable and every requester ready SHALL be low.
REQ-026 In BURST with lock_id not valid, the arbiter SHALL idle and keep the lock (no re-arbitration).
REQ-027 Ready outputs SHALL be combinational from valid, state, ptr and handshake_ready; no combinational path SHALL exist from any data input to any ready.

Reset
REQ-028 On RESET high at posedge CLK: FSM=IDLE, ptr=0, lock_id=0, handshake_valid=0, out=0, out_id=0, out_last=0.
REQ-029 While RESET is high, all handshake_arr_<i>_ready SHALL be low.
REQ-030 RESET asserted mid-packet SHALL discard the lock and the buffered word; no word is emitted for that cycle.

Structure
REQ-031 Package bar_arb_pkg SHALL hold N_REQ, typedef id_t (logic [1:0]) and the FSM state enum arb_state_t {IDLE, BURST}.
REQ-032 The round-robin priority search SHALL be a combinational sub-module rr_pick (inputs req[2:0] and ptr; outputs grant one-hot and grant_id).
REQ-033 Output register, FSM and ptr SHALL reside in handshake_rr_arbiter.

Verification
REQ-034 Reset, then all three valid with last=1 and handshake_ready=1 -> grants 0,1,2,0 on consecutive cycles; out_id 0,1,2 from cycle 2 onward.
REQ-035 Req1 sends 3-word packet (last on word 3) while req0/req2 valid -> out_id 1,1,1 contiguous, then grant to 2 (ptr=2).
REQ-036 handshake_ready=0 for 4 cycles with handshake_valid=1 -> out stable, all requester readies low; readies resume the cycle handshake_ready rises.
REQ-037 Req2 alone, last=1, accepted -> ptr wraps to 0; next simultaneous req0/req2 grants 0.
REQ-038 RESET pulsed during a BURST from req1 -> next cycle handshake_valid=0, state IDLE, ptr=0; req0 wins next arbitration.
REQ-039 Bind-style monitor asserts: one-hot-or-zero readies, output stability under backpressure, no foreign grant during BURST, across 10k random cycles.
